// File: rtl/onehot_decoder_pkg.sv
// Shared types for the registered one-hot decoder.
//   dec_mode_e   : per-beat decode mode carried on in_mode
//   skid_state_e : occupancy of the 2-entry output skid buffer
package onehot_decoder_pkg;

  typedef enum logic [1:0] {
    DEC_ONEHOT = 2'b00,  // result = D(idx)
    DEC_THERMO = 2'b01,  // result = bits [b:0] set
    DEC_ACCUM  = 2'b10,  // acc |= D(idx), result = new acc
    DEC_ACCLR  = 2'b11   // acc  = D(idx), result = D(idx)
  } dec_mode_e;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/onehot_decode_core.sv
// Combinational index decoder.
//   idx    in  IN_W     index to decode
//   onehot out 2**IN_W  single bit b set (all-zeros for idx 0 when ZERO_IS_NONE)
//   thermo out 2**IN_W  bits [b:0] set (all-zeros for idx 0 when ZERO_IS_NONE)
// With ZERO_IS_NONE the bit position is b = idx-1, otherwise b = idx.
module onehot_decode_core #(
  parameter int IN_W         = 5,
  parameter bit ZERO_IS_NONE = 1'b1
) (
  input  logic [IN_W-1:0]      idx,
  output logic [2**IN_W-1:0]   onehot,
  output logic [2**IN_W-1:0]   thermo
);

  localparam int OUT_W = 2**IN_W;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (ZERO_IS_NONE) onehot[i] = (int'(idx) == i + 1);
      else              onehot[i] = (int'(idx) == i);
    end
  end

  // Filling every bit below the set bit gives the thermometer code; the
  // explicit zero test keeps the "no bit set" case from wrapping to all-ones.
  assign thermo = (onehot == '0) ? '0 : (onehot | (onehot - OUT_W'(1)));

endmodule

// File: rtl/onehot_decoder_pipe.sv
// Registered index decoder with one-hot / thermometer / OR-accumulate modes
// and a valid/ready output stream behind a 2-entry skid buffer.
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       index/mode beat valid
//   in_ready   out  1       beat can be accepted (depends on state only)
//   in_index   in   IN_W    index to decode
//   in_mode    in   2       see dec_mode_e
//   out_valid  out  1       out_data valid
//   out_ready  in   1       consumer takes out_data
//   out_data   out  2**IN_W decoded vector, holds last value after a pop
//   acc_state  out  2**IN_W accumulator contents
module onehot_decoder_pipe
  import onehot_decoder_pkg::*;
#(
  parameter int                 IN_W         = 5,
  parameter bit                 ZERO_IS_NONE = 1'b1,
  parameter logic [2**IN_W-1:0] RESET_OUT    = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     in_index,
  input  logic [1:0]          in_mode,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2**IN_W-1:0]  out_data,
  output logic [2**IN_W-1:0]  acc_state
);

  localparam int OUT_W = 2**IN_W;

  skid_state_e      state_q, state_d;
  logic [OUT_W-1:0] onehot, thermo, result;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [OUT_W-1:0] out_q, skid_q;
  logic             accept;
  logic             load_out, load_skid, pop_skid;

  onehot_decode_core #(
    .IN_W         (IN_W),
    .ZERO_IS_NONE (ZERO_IS_NONE)
  ) u_core (
    .idx    (in_index),
    .onehot (onehot),
    .thermo (thermo)
  );

  // in_ready comes straight from the state register, so out_ready has no
  // combinational route to it.
  assign in_ready  = (state_q != SKID_TWO);
  assign out_valid = (state_q != SKID_EMPTY);
  assign accept    = in_valid & in_ready;
  assign out_data  = out_q;
  assign acc_state = acc_q;

  // Mode mux: accumulate modes report the post-update accumulator value.
  always_comb begin
    result = onehot;
    acc_d  = acc_q;
    case (dec_mode_e'(in_mode))
      DEC_ONEHOT: result = onehot;
      DEC_THERMO: result = thermo;
      DEC_ACCUM: begin
        acc_d  = acc_q | onehot;
        result = acc_q | onehot;
      end
      DEC_ACCLR: begin
        acc_d  = onehot;
        result = onehot;
      end
      default: result = onehot;
    endcase
  end

  // Skid buffer control. out_q is the head entry, skid_q the second one.
  always_comb begin
    state_d   = state_q;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          load_out = 1'b1;
          state_d  = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && out_ready) begin
          // Head leaves and the new result takes its place in the same edge.
          load_out = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = SKID_TWO;
        end else if (out_ready) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_TWO: begin
        if (out_ready) begin
          pop_skid = 1'b1;
          state_d  = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // NOTE: sequential state is written with <= so every flop samples the
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= SKID_EMPTY;
    else        state_q <= state_d;
  end

  // NOTE: skid_q is only read when the state says it is occupied, so its
  // reset is not functionally needed; it is cleared anyway to keep it X-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q  <= RESET_OUT;
      skid_q <= '0;
      acc_q  <= RESET_OUT;
    end else begin
      if (load_out)      out_q <= result;
      else if (pop_skid) out_q <= skid_q;
      if (load_skid)     skid_q <= result;
      if (accept)        acc_q <= acc_d;
    end
  end

  // An unknown index on a valid beat is a producer bug; nothing here repairs it.
  a_index_known: assert property (
    @(posedge clk) disable iff (!rst_n) in_valid |-> !$isunknown(in_index)
  );

endmodule

// File: tb/tb_onehot_decoder_pipe.sv
module tb_onehot_decoder_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  in_index;
  logic [1:0]  in_mode;
  logic [31:0] out_data, acc_state;

  logic        in_valid3, in_ready3, out_valid3, out_ready3;
  logic [2:0]  in_index3;
  logic [1:0]  in_mode3;
  logic [7:0]  out_data3, acc_state3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  onehot_decoder_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_index  (in_index),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .acc_state (acc_state)
  );

  onehot_decoder_pipe #(.IN_W(3), .ZERO_IS_NONE(1'b0)) dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .in_index  (in_index3),
    .in_mode   (in_mode3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .out_data  (out_data3),
    .acc_state (acc_state3)
  );

  // Drives one beat from a negedge; returns on the negedge after acceptance.
  task automatic push(input logic [1:0] mode, input logic [4:0] idx);
    int n = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_index = idx;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b want 1", in_ready); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
    checks++; if (acc_state !== 32'h0) begin errors++; $display("FAIL rst_acc got %h want 0", acc_state); end
    checks++; if (out_valid3 !== 1'b0) begin errors++; $display("FAIL rst_out_valid3 got %b want 0", out_valid3); end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // idx 0..31 back-to-back, one-hot, consumer always ready.
  task automatic test_onehot_sweep();
    logic [31:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      in_valid = 1'b1;
      in_mode  = 2'b00;
      in_index = k[4:0];
      @(negedge clk);
      exp = (k == 0) ? 32'h0 : (32'h1 << (k - 1));
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sweep_valid idx=%0d got %b want 1", k, out_valid); end
      checks++; if (out_data !== exp) begin errors++; $display("FAIL sweep_data idx=%0d got %h want %h", k, out_data, exp); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sweep_in_ready idx=%0d got %b want 1", k, in_ready); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sweep_idle_valid got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h4000_0000) begin errors++; $display("FAIL sweep_hold got %h want 40000000", out_data); end
  endtask

  task automatic test_thermo();
    logic [2:0] idxs [3];
    logic [7:0] exps [3];
    idxs = '{3'd0, 3'd3, 3'd7};
    exps = '{8'h01, 8'h0F, 8'hFF};
    for (int i = 0; i < 3; i++) begin
      in_valid3 = 1'b1;
      in_mode3  = 2'b01;
      in_index3 = idxs[i];
      @(negedge clk);
      checks++; if (out_valid3 !== 1'b1) begin errors++; $display("FAIL thermo_valid idx=%0d got %b want 1", idxs[i], out_valid3); end
      checks++; if (out_data3 !== exps[i]) begin errors++; $display("FAIL thermo_data idx=%0d got %h want %h", idxs[i], out_data3, exps[i]); end
    end
    in_valid3 = 1'b0;
    checks++; if (acc_state3 !== 8'h00) begin errors++; $display("FAIL thermo_acc got %h want 00", acc_state3); end
  endtask

  task automatic test_accum();
    logic [1:0]  modes [4];
    logic [4:0]  idxs  [4];
    logic [31:0] exps  [4];
    modes = '{2'b10, 2'b10, 2'b10, 2'b11};
    idxs  = '{5'd2, 5'd5, 5'd2, 5'd4};
    exps  = '{32'h02, 32'h12, 32'h12, 32'h08};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_mode  = modes[i];
      in_index = idxs[i];
      @(negedge clk);
      checks++; if (out_data !== exps[i]) begin errors++; $display("FAIL accum_data step=%0d got %h want %h", i, out_data, exps[i]); end
      checks++; if (acc_state !== exps[i]) begin errors++; $display("FAIL accum_acc step=%0d got %h want %h", i, acc_state, exps[i]); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (acc_state !== 32'h08) begin errors++; $display("FAIL accum_final got %h want 08", acc_state); end
  endtask

  task automatic test_back_pressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'b00;
    in_index  = 5'd1;
    @(negedge clk);
    checks++; if (out_data !== 32'h1) begin errors++; $display("FAIL bp_first got %h want 1", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b want 1", in_ready); end
    in_index = 5'd2;
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full got %b want 0", in_ready); end
    in_index = 5'd3;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_data !== 32'h1 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold cyc=%0d got %h/%b want 1/1", i, out_data, out_valid); end
      @(negedge clk);
    end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got %b want 0", in_ready); end
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_data !== 32'h2) begin errors++; $display("FAIL bp_second got %h want 2", out_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen got %b want 1", in_ready); end
    @(negedge clk);
    checks++; if (out_data !== 32'h4 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_third got %h/%b want 4/1", out_data, out_valid); end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained got %b want 0", out_valid); end
    checks++; if (out_data !== 32'h4) begin errors++; $display("FAIL bp_last_hold got %h want 4", out_data); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b1;
    push(2'b11, 5'd1);
    for (int i = 2; i <= 7; i++) push(2'b10, 5'(i));
    out_ready = 1'b0;
    push(2'b10, 5'd8);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_two_state got %b want 0", in_ready); end
    checks++; if (acc_state !== 32'hFF) begin errors++; $display("FAIL ar_acc got %h want ff", acc_state); end
    checks++; if (out_data !== 32'h7F) begin errors++; $display("FAIL ar_head got %h want 7f", out_data); end
    in_valid = 1'b1;
    in_mode  = 2'b00;
    in_index = 5'd5;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready got %b want 1", in_ready); end
    checks++; if (acc_state !== 32'h0) begin errors++; $display("FAIL ar_acc_clr got %h want 0", acc_state); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL ar_out_clr got %h want 0", out_data); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    push(2'b00, 5'd1);
    checks++; if (out_data !== 32'h1 || out_valid !== 1'b1) begin errors++; $display("FAIL ar_post got %h/%b want 1/1", out_data, out_valid); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_post_drain got %b want 0", out_valid); end
  endtask

  // Random traffic against a queue model; also wiggles out_ready between
  // edges to confirm in_ready does not follow it.
  task automatic test_random();
    logic [31:0] q [$];
    logic [31:0] macc, oh, res, exp;
    logic [32:0] th;
    logic        r;
    macc = 32'h0;
    for (int c = 0; c < 10000; c++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_mode   = 2'($urandom_range(0, 3));
      in_index  = 5'($urandom_range(0, 31));
      #1 r = in_ready;
      out_ready = ~out_ready;
      #1;
      checks++; if (in_ready !== r) begin errors++; $display("FAIL rnd_ready_comb cyc=%0d got %b want %b", c, in_ready, r); end
      out_ready = ~out_ready;
      checks++; if (acc_state !== macc) begin errors++; $display("FAIL rnd_acc cyc=%0d got %h want %h", c, acc_state, macc); end
      checks++; if (out_valid !== (q.size() != 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got %b want %b", c, out_valid, q.size() != 0); end
      if (out_valid && out_ready && q.size() != 0) begin
        exp = q.pop_front();
        checks++; if (out_data !== exp) begin errors++; $display("FAIL rnd_data cyc=%0d got %h want %h", c, out_data, exp); end
      end
      if (in_valid && in_ready) begin
        oh = (in_index == 5'd0) ? 32'h0 : (32'h1 << (in_index - 5'd1));
        th = (33'h1 << in_index) - 33'h1;
        case (in_mode)
          2'b00: res = oh;
          2'b01: res = th[31:0];
          2'b10: begin macc = macc | oh; res = macc; end
          default: begin macc = oh; res = oh; end
        endcase
        q.push_back(res);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int n = 0; n < 10 && q.size() != 0; n++) begin
      exp = q.pop_front();
      checks++; if (out_data !== exp || out_valid !== 1'b1) begin errors++; $display("FAIL rnd_drain got %h/%b want %h/1", out_data, out_valid, exp); end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rnd_final_valid got %b want 0", out_valid); end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_mode    = 2'b00;
    in_index   = 5'd0;
    out_ready  = 1'b1;
    in_valid3  = 1'b0;
    in_mode3   = 2'b00;
    in_index3  = 3'd0;
    out_ready3 = 1'b1;
    test_reset();
    test_onehot_sweep();
    test_thermo();
    test_accum();
    test_back_pressure();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
